// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results queue in a small FIFO, load results
// take the port directly unless the FIFO is full; also tracks per-register busy bits.
module rf_writeback_arbiter #(
    parameter int XLEN       = 64,
    parameter int REGW       = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [REGW-1:0]               alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [REGW-1:0]               mem_rd,
    input  logic [XLEN-1:0]               mem_data,
    input  logic                          issue_valid,
    input  logic [REGW-1:0]               issue_rd,
    input  logic [REGW-1:0]               rs1,
    input  logic [REGW-1:0]               rs2,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic                          rf_we,
    output logic [REGW-1:0]               rf_rd,
    output logic [XLEN-1:0]               rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            NREG     = 1 << REGW;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [REGW-1:0] fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [NREG-1:0] busy;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            sel_mem;
    logic            sel_valid;
    logic [REGW-1:0] sel_rd;
    logic [XLEN-1:0] sel_data;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign alu_ready  = reset & ~full;
    assign mem_ready  = reset & ~full;
    assign push       = alu_valid & alu_ready;

    // A full FIFO outranks loads so ALU results can never deadlock behind them.
    assign sel_mem    = ~full & mem_valid;
    assign pop        = ~sel_mem & ~empty;
    assign sel_valid  = sel_mem | pop;
    assign sel_rd     = sel_mem ? mem_rd   : fifo_rd[rd_ptr];
    assign sel_data   = sel_mem ? mem_data : fifo_data[rd_ptr];

    assign fifo_count = count;
    assign rs1_busy   = busy[rs1] & (rs1 != '0);
    assign rs2_busy   = busy[rs2] & (rs2 != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= alu_rd;
            fifo_data[wr_ptr] <= alu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (sel_valid) begin
            rf_we    <= (sel_rd != '0);
            rf_rd    <= sel_rd;
            rf_wdata <= sel_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // The later assignment lets a same-edge reissue override the commit clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (rf_we) busy[rf_rd] <= 1'b0;
            if (issue_valid && (issue_rd != '0)) busy[issue_rd] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: queue-based reference model feeds a write scoreboard
// that a separate monitor drains; directed scenarios followed by randomized traffic.
module tb_rf_writeback_arbiter;

    localparam int XLEN  = 64;
    localparam int REGW  = 5;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [REGW-1:0] alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            mem_valid = 1'b0;
    logic            mem_ready;
    logic [REGW-1:0] mem_rd = '0;
    logic [XLEN-1:0] mem_data = '0;
    logic            issue_valid = 1'b0;
    logic [REGW-1:0] issue_rd = '0;
    logic [REGW-1:0] rs1 = '0;
    logic [REGW-1:0] rs2 = '0;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rf_we;
    logic [REGW-1:0] rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [2:0]      fifo_count;

    rf_writeback_arbiter #(.XLEN(XLEN), .REGW(REGW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] data;
    } item_t;

    typedef struct {
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] data;
        int              cyc;
    } exp_t;

    item_t           mq[$];
    exp_t            eq[$];
    bit              mbusy[32];
    logic            m_we = 1'b0;
    logic [REGW-1:0] m_rd = '0;
    logic [XLEN-1:0] m_data = '0;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every committed write must match the scoreboard head in content and cycle.
    exp_t mon_e;
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (eq.size() > 0 && eq[0].cyc == cyc) begin
                mon_e = eq.pop_front();
                chk("wr_we", rf_we, 1);
                if (rf_we) begin
                    chk("wr_rd", rf_rd, mon_e.rd);
                    chk("wr_data", rf_wdata, mon_e.data);
                end
            end else begin
                chk("wr_spurious", rf_we, 0);
            end
        end
    end

    task automatic step(input bit av, input logic [REGW-1:0] ard, input logic [XLEN-1:0] ad,
                        input bit mv, input logic [REGW-1:0] mrd, input logic [XLEN-1:0] md,
                        input bit iv, input logic [REGW-1:0] ird,
                        input logic [REGW-1:0] r1, input logic [REGW-1:0] r2);
        item_t it;
        bit    have;
        bit    acc;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
        #1;
        chk("alu_ready", alu_ready, mq.size() < DEPTH);
        chk("mem_ready", mem_ready, mq.size() != DEPTH);
        chk("fifo_count", fifo_count, mq.size());
        chk("rs1_busy", rs1_busy, mbusy[r1] && r1 != 0);
        chk("rs2_busy", rs2_busy, mbusy[r2] && r2 != 0);
        chk("rf_we", rf_we, m_we);
        chk("rf_rd_hold", rf_rd, m_rd);
        chk("rf_wdata_hold", rf_wdata, m_data);
        acc  = av && (mq.size() < DEPTH);
        have = 1'b0;
        if (mq.size() == DEPTH) begin
            it = mq.pop_front(); have = 1'b1;
        end else if (mv) begin
            it = '{rd: mrd, data: md}; have = 1'b1;
        end else if (mq.size() > 0) begin
            it = mq.pop_front(); have = 1'b1;
        end
        if (acc) mq.push_back('{rd: ard, data: ad});
        if (m_we) mbusy[m_rd] = 1'b0;
        if (iv && ird != 0) mbusy[ird] = 1'b1;
        if (have) begin
            m_rd = it.rd; m_data = it.data; m_we = (it.rd != 0);
        end else begin
            m_we = 1'b0;
        end
        if (m_we) eq.push_back('{rd: m_rd, data: m_data, cyc: cyc + 1});
    endtask

    task automatic idle(input int n, input logic [REGW-1:0] r1);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        reset = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_rs1_busy", rs1_busy, 0);
        chk("rst_rs2_busy", rs2_busy, 0);
        mq.delete();
        eq.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        m_we = 1'b0; m_rd = '0; m_data = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;

        // ALU-only latency
        step(1, 5, 64'hAA, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 0);

        // load and ALU together
        step(1, 9, 64'h99, 1, 7, 64'h77, 0, 0, 0, 0);
        idle(3, 0);

        // fill FIFO while loads hog the port
        for (int i = 0; i < 5; i++)
            step(1, REGW'(20 + i), 64'h100 + 64'(i), 1, REGW'(12 + i), 64'h200 + 64'(i), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 1, REGW'(25 + i), 64'h300 + 64'(i), 0, 0, 0, 0);
        idle(6, 0);

        // busy scoreboard, without and with a same-edge reissue
        step(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        step(1, 3, 64'h33, 0, 0, 0, 0, 0, 3, 0);
        idle(4, 3);
        step(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        step(1, 3, 64'h34, 0, 0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        idle(3, 3);

        // rd=0 result is consumed silently
        step(1, 0, 64'hFF, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 0);

        // reset mid-stream with three queued ALU results and busy registers
        step(0, 0, 0, 0, 0, 0, 1, 10, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 11, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, REGW'(1 + i), 64'h400 + 64'(i), 1, 0, 0, 0, 0, 10, 11);
        step(0, 0, 0, 1, 4, 64'h500, 0, 0, 10, 11);
        do_reset();
        idle(6, 10);

        // randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if (n % 500 == 499) do_reset();
            step($urandom_range(0, 99) < 60, REGW'($urandom_range(0, 31)), {$urandom, $urandom},
                 $urandom_range(0, 99) < 40, REGW'($urandom_range(0, 31)), {$urandom, $urandom},
                 $urandom_range(0, 99) < 30, REGW'($urandom_range(0, 31)),
                 REGW'($urandom_range(0, 31)), REGW'($urandom_range(0, 31)));
        end
        idle(8, 0);
        @(negedge clk);
        #2;
        chk("scoreboard_drained", eq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
